// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: core FSM encodings, scheduler states, warp count.
package gpu_pkg;

  // Default warp count, shared with the context multiplexer.
  localparam int NUM_WARPS_DEF = 2;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    WS_IDLE,
    WS_PICK,
    WS_RUN,
    WS_SWAP,
    WS_FINISH
  } warp_sched_state_t;

endpackage

// File: rtl/warp_scheduler_if.sv
// Scheduler <-> dispatcher / context multiplexer signal bundle.
interface warp_scheduler_if #(
  parameter int NUM_WARPS = gpu_pkg::NUM_WARPS_DEF,
  parameter int SEL_W     = $clog2(NUM_WARPS)
);
  logic                 start;
  logic [NUM_WARPS-1:0] warp_valid;
  logic [NUM_WARPS-1:0] warp_done;
  logic [2:0]           core_state;
  logic                 mem_stall;
  logic [SEL_W-1:0]     warp_select;
  logic                 swap;
  logic                 hold;
  logic                 all_done;
  logic                 busy;

  // Dispatcher / multiplexer side.
  modport master (
    output start, warp_valid, warp_done, core_state, mem_stall,
    input  warp_select, swap, hold, all_done, busy
  );

  // Scheduler side.
  modport slave (
    input  start, warp_valid, warp_done, core_state, mem_stall,
    output warp_select, swap, hold, all_done, busy
  );
endinterface

// File: rtl/rr_next_warp.sv
// Round-robin picker: first set bit of mask after cur, wrapping modulo NUM_WARPS.
module rr_next_warp #(
  parameter int NUM_WARPS = 2,
  parameter int SEL_W     = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] mask,
  input  logic [SEL_W-1:0]     cur,
  output logic [SEL_W-1:0]     nxt,
  output logic                 found
);
  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest eligible warp wins.
  // NUM_WARPS is a power of two, so the SEL_W-bit add wraps naturally.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int k = NUM_WARPS; k >= 1; k--) begin
      idx = cur + SEL_W'(k);
      if (mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/warp_scheduler.sv
// Warp scheduler: picks which warp owns the shared core pipeline each cycle.
module warp_scheduler
  import gpu_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int QUANTUM   = 8,
  parameter int SEL_W     = $clog2(NUM_WARPS)
) (
  input logic             clk,
  input logic             reset,
  warp_scheduler_if.slave bus
);
  localparam logic [7:0] QLAST = 8'(QUANTUM - 1);

  warp_sched_state_t    state, state_nxt;
  logic [NUM_WARPS-1:0] valid_q, done_q, done_now, elig, pick_mask;
  logic [SEL_W-1:0]     sel_q, pick_cur, pick_idx;
  logic                 pick_found;
  logic [7:0]           qcnt;
  logic                 launch, active_done, is_update, quantum_hit;

  assign launch      = bus.start && (state == WS_IDLE || state == WS_FINISH);
  // Done flags for non-active warps are latched so a short pulse still retires them.
  assign done_now    = done_q | bus.warp_done;
  assign elig        = valid_q & ~done_now;
  assign active_done = done_now[sel_q];
  assign is_update   = bus.core_state == CORE_UPDATE;
  assign quantum_hit = is_update && (qcnt == QLAST);

  // One picker serves both roles: PICK searches from index 0, RUN searches after
  // the active warp with the active warp masked out ("another eligible warp").
  always_comb begin
    pick_mask = elig;
    pick_cur  = SEL_W'(NUM_WARPS - 1);
    if (state == WS_RUN) begin
      pick_mask = elig & ~(NUM_WARPS'(1) << sel_q);
      pick_cur  = sel_q;
    end
  end

  rr_next_warp #(.NUM_WARPS(NUM_WARPS), .SEL_W(SEL_W)) u_rr (
    .mask  (pick_mask),
    .cur   (pick_cur),
    .nxt   (pick_idx),
    .found (pick_found)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= WS_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. All triggers share one target, so precedence only decides
  // done (may finish) versus stall/quantum (need an alternative warp).
  always_comb begin
    state_nxt = state;
    case (state)
      WS_IDLE, WS_FINISH: if (bus.start) state_nxt = (|bus.warp_valid) ? WS_PICK : WS_FINISH;
      WS_PICK:            state_nxt = pick_found ? WS_RUN : WS_FINISH;
      WS_RUN: begin
        if (active_done)                                   state_nxt = pick_found ? WS_SWAP : WS_FINISH;
        else if (pick_found && (bus.mem_stall || quantum_hit)) state_nxt = WS_SWAP;
      end
      WS_SWAP:            state_nxt = WS_RUN;
      default:            state_nxt = WS_IDLE;
    endcase
  end

  // Datapath: sampled valid mask, latched done flags, active warp, quantum counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
      sel_q   <= '0;
      qcnt    <= '0;
    end else begin
      if (launch) begin
        valid_q <= bus.warp_valid;
        done_q  <= '0;
      end else begin
        done_q  <= done_now;
      end
      if ((state == WS_PICK && pick_found) || (state == WS_RUN && state_nxt == WS_SWAP))
        sel_q <= pick_idx;
      // Counter is zero on every entry to RUN; it wraps at the quantum boundary.
      if (state != WS_RUN) qcnt <= '0;
      else if (is_update)  qcnt <= quantum_hit ? 8'd0 : qcnt + 8'd1;
    end
  end

  // Outputs decoded from state; warp_select comes straight from its register.
  always_comb begin
    bus.warp_select = sel_q;
    bus.swap        = (state == WS_SWAP);
    bus.hold        = (state != WS_RUN);
    bus.busy        = (state == WS_PICK) || (state == WS_RUN) || (state == WS_SWAP);
    bus.all_done    = (state == WS_FINISH);
  end
endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the scheduling rules.
module tb_warp_scheduler;
  localparam int NW = 2;
  localparam int Q  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  warp_scheduler_if #(.NUM_WARPS(NW)) bus();
  warp_scheduler #(.NUM_WARPS(NW), .QUANTUM(Q)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: which phase the kernel is in, who owns the core,
  // how many UPDATEs the owner has retired, and the warp bookkeeping.
  typedef enum {M_IDLE, M_PICK, M_RUN, M_SWAP, M_FIN} mphase_t;
  mphase_t     m_ph = M_IDLE;
  int          m_sel = 0;
  int          m_cnt = 0;
  bit [NW-1:0] m_valid = '0;
  bit [NW-1:0] m_done = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    bit [NW-1:0] dn, el;
    int nxt;
    bit have;
    nxt = 0;
    have = 1'b0;
    if (reset) begin
      m_ph = M_IDLE; m_sel = 0; m_cnt = 0; m_valid = '0; m_done = '0;
      return;
    end
    dn = m_done | bus.warp_done;
    el = m_valid & ~dn;
    m_done = dn;
    case (m_ph)
      M_IDLE, M_FIN: if (bus.start) begin
        m_valid = bus.warp_valid;
        m_done  = '0;
        m_ph    = (bus.warp_valid != 0) ? M_PICK : M_FIN;
      end
      M_PICK: begin
        for (int i = NW - 1; i >= 0; i--) if (el[i]) begin have = 1'b1; nxt = i; end
        if (have) begin m_sel = nxt; m_cnt = 0; m_ph = M_RUN; end
        else m_ph = M_FIN;
      end
      M_RUN: begin
        for (int k = NW - 1; k >= 1; k--)
          if (el[(m_sel + k) % NW]) begin have = 1'b1; nxt = (m_sel + k) % NW; end
        if (dn[m_sel]) begin
          if (have) begin m_sel = nxt; m_ph = M_SWAP; end
          else m_ph = M_FIN;
        end else if (have && (bus.mem_stall || (bus.core_state == 3'b110 && m_cnt == Q - 1))) begin
          m_sel = nxt; m_ph = M_SWAP;
        end else if (bus.core_state == 3'b110) begin
          m_cnt = (m_cnt + 1) % Q;
        end
      end
      M_SWAP: begin m_cnt = 0; m_ph = M_RUN; end
      default: m_ph = M_IDLE;
    endcase
  endtask

  // Advance one clock, update the model, then compare all outputs off-edge.
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    chk("warp_select", bus.warp_select, m_sel);
    chk("swap",        bus.swap,        m_ph == M_SWAP);
    chk("hold",        bus.hold,        m_ph != M_RUN);
    chk("busy",        bus.busy,        m_ph inside {M_PICK, M_RUN, M_SWAP});
    chk("all_done",    bus.all_done,    m_ph == M_FIN);
  endtask

  task automatic drv(input bit st, input bit [NW-1:0] v, input bit [NW-1:0] d,
                     input bit [2:0] cs, input bit ms);
    bus.start = st; bus.warp_valid = v; bus.warp_done = d;
    bus.core_state = cs; bus.mem_stall = ms;
  endtask

  task automatic launch(input bit [NW-1:0] v);
    drv(1'b1, v, '0, 3'b001, 1'b0);
    step();
    bus.start = 1'b0;
    step();
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    drv(1'b0, '0, '0, 3'b000, 1'b0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    int swq[$];
    int nsw;
    bit [NW-1:0] dlev;
    bit [2:0] cs;

    // Reset values
    reset = 1'b1;
    drv(1'b0, '0, '0, 3'b000, 1'b0);
    step(); step();
    chk("rst_sel", bus.warp_select, 0);
    chk("rst_swap", bus.swap, 0);
    chk("rst_hold", bus.hold, 1);
    chk("rst_all_done", bus.all_done, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;

    // Quantum swap: UPDATE every 4 cycles, swap after every second UPDATE
    launch(2'b11);
    chk("q_first_sel", bus.warp_select, 0);
    chk("q_run_hold", bus.hold, 0);
    for (int c = 0; c < 48; c++) begin
      bus.core_state = (c % 4 == 3) ? 3'b110 : 3'b101;
      step();
      if (bus.swap === 1'b1) begin
        swq.push_back(int'(bus.warp_select));
        chk("q_hold_in_swap", bus.hold, 1);
      end
    end
    chk("q_swap_count", swq.size(), 6);
    for (int i = 0; i < swq.size(); i++) chk("q_order", swq[i], (i % 2 == 0) ? 1 : 0);

    // Memory stall swaps immediately; new warp keeps the core until its quantum
    rst_pulse();
    launch(2'b11);
    bus.core_state = 3'b101;
    step(); step(); step();
    bus.core_state = 3'b100; bus.mem_stall = 1'b1;
    step();
    chk("ms_swap", bus.swap, 1);
    chk("ms_sel", bus.warp_select, 1);
    bus.mem_stall = 1'b0; bus.core_state = 3'b101;
    for (int c = 0; c < 7; c++) begin
      step();
      chk("ms_keep_sel", bus.warp_select, 1);
    end
    bus.core_state = 3'b110; step();
    bus.core_state = 3'b101; step();
    chk("ms_no_early_swap", bus.swap, 0);
    bus.core_state = 3'b110; step();
    chk("ms_quantum_swap", bus.swap, 1);
    chk("ms_quantum_sel", bus.warp_select, 0);

    // Stall with no alternative warp: never swaps
    rst_pulse();
    launch(2'b01);
    bus.core_state = 3'b100; bus.mem_stall = 1'b1;
    nsw = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.swap !== 1'b0) nsw++;
    end
    chk("ns_swaps", nsw, 0);
    chk("ns_sel", bus.warp_select, 0);
    chk("ns_busy", bus.busy, 1);

    // Done sequencing: inactive warp done first, then active warp -> FINISH
    rst_pulse();
    launch(2'b11);
    bus.core_state = 3'b101; bus.warp_done = 2'b10;
    step();
    chk("dn_other_no_swap", bus.swap, 0);
    step(); step();
    chk("dn_other_sel", bus.warp_select, 0);
    bus.warp_done = 2'b11; bus.core_state = 3'b111;
    step();
    chk("dn_all_done", bus.all_done, 1);
    chk("dn_busy", bus.busy, 0);
    chk("dn_swap", bus.swap, 0);
    chk("dn_hold", bus.hold, 1);
    bus.warp_done = 2'b00;
    step();
    chk("dn_sticky", bus.all_done, 1);

    // Simultaneous triggers: done path wins, single swap to warp 1
    rst_pulse();
    launch(2'b11);
    bus.core_state = 3'b110; step();
    bus.core_state = 3'b001; step();
    bus.core_state = 3'b110; bus.mem_stall = 1'b1; bus.warp_done = 2'b01;
    step();
    chk("sim_swap", bus.swap, 1);
    chk("sim_sel", bus.warp_select, 1);
    bus.mem_stall = 1'b0; bus.core_state = 3'b001;
    step();
    chk("sim_single_pulse", bus.swap, 0);
    bus.core_state = 3'b110;
    step();
    chk("sim_stay", bus.warp_select, 1);
    chk("sim_busy", bus.busy, 1);

    // Reset during the SWAP cycle, then relaunch from warp 0
    rst_pulse();
    launch(2'b11);
    bus.core_state = 3'b100; bus.mem_stall = 1'b1;
    step();
    chk("rs_in_swap", bus.swap, 1);
    reset = 1'b1; bus.mem_stall = 1'b0;
    step();
    chk("rs_sel", bus.warp_select, 0);
    chk("rs_swap", bus.swap, 0);
    chk("rs_hold", bus.hold, 1);
    chk("rs_busy", bus.busy, 0);
    reset = 1'b0;
    launch(2'b11);
    chk("rs_relaunch_sel", bus.warp_select, 0);
    chk("rs_relaunch_hold", bus.hold, 0);

    // Launch with no valid warps finishes directly; start from FINISH relaunches
    rst_pulse();
    drv(1'b1, 2'b00, '0, 3'b000, 1'b0);
    step();
    chk("empty_all_done", bus.all_done, 1);
    chk("empty_busy", bus.busy, 0);
    bus.start = 1'b0; step();
    drv(1'b1, 2'b10, '0, 3'b000, 1'b0);
    step();
    chk("refin_all_done", bus.all_done, 0);
    chk("refin_busy", bus.busy, 1);
    bus.start = 1'b0; step();
    chk("refin_sel", bus.warp_select, 1);

    // Random traffic against the model
    rst_pulse();
    dlev = '0;
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      bus.start = ($urandom_range(0, 19) == 0);
      bus.warp_valid = NW'($urandom);
      if (bus.start || reset) dlev = '0;
      if ($urandom_range(0, 24) == 0) dlev[$urandom_range(0, NW - 1)] = 1'b1;
      bus.warp_done = dlev;
      cs = 3'($urandom);
      bus.core_state = cs;
      bus.mem_stall = (cs == 3'b100) && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Upstream control stage of the per-core warp context multiplexer. Decides which warp owns the shared fetch/decode/execute pipeline each cycle.
- Drives a registered warp_select to the context multiplexer, plus a one-cycle swap bubble so the multiplexer can save and restore context.
- Round-robin across eligible warps. A swap happens on a memory stall, at instruction-quantum expiry, or when the active warp finishes.

Parameters:
- NUM_WARPS, 2: warps multiplexed per core; power of two, 2..4.
- QUANTUM, 8: instructions retired before a forced swap; 1..255.
- SEL_W, $clog2(NUM_WARPS): width of warp_select (derived; 1 at default).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- start  in  1  kernel launch pulse from dispatcher
- warp_valid  in  NUM_WARPS  warp has thread_count>0 for this block
- warp_done  in  NUM_WARPS  per-warp done flags returned by context multiplexer
- core_state  in  3  state of active warp's core FSM (IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111)
- mem_stall  in  1  active warp in WAIT with at least one LSU thread still REQUESTING/WAITING
- warp_select  out  SEL_W  active warp index
- swap  out  1  one-cycle pulse: context save/restore cycle
- hold  out  1  freeze core FSM/fetcher/LSU issue this cycle
- all_done  out  1  every valid warp done; sticky until reset or start
- busy  out  1  kernel in progress

Behaviour:
- Reset values: warp_select=0, swap=0, hold=1, all_done=0, busy=0. Quantum counter=0. FSM=IDLE.
- FSM states: IDLE, PICK, RUN, SWAP, FINISH.
- IDLE: hold=1.
  - start with warp_valid!=0 -> PICK, busy=1.
  - start with warp_valid==0 -> FINISH directly, all_done=1 next cycle.
  - start ignored outside IDLE and FINISH.
- PICK (1 cycle): warp_select <= lowest-index eligible warp (valid & ~done). hold=1. -> RUN.
- RUN: hold=0. Quantum counter increments on each cycle with core_state==UPDATE; cleared on entry to RUN.
- Swap triggers, evaluated in RUN:
  - (a) mem_stall=1 and another eligible warp exists.
  - (b) core_state==UPDATE and counter==QUANTUM-1 and another eligible warp exists.
  - (c) warp_done[active]=1.
- Swap target: next eligible index after warp_select, modulo NUM_WARPS (round-robin).
- No other eligible warp on (a) or (b): stay in RUN, no swap. Counter wraps to 0 on (b).
- (c) with no eligible warp left -> FINISH.
- Precedence when several triggers fire in one cycle: (c) > (a) > (b).
- SWAP is exactly 1 cycle: swap=1, hold=1, warp_select updated on the same edge that enters SWAP. Then -> RUN.
  - Latency: trigger cycle N -> swap and new warp_select visible at N+1 -> new warp executes at N+2.
- Swap is never taken in FETCH, DECODE or EXECUTE. Only trigger (a) may interrupt an in-flight instruction; the stalled warp resumes at WAIT with its LSU state preserved by the multiplexer.
- FINISH: hold=1, busy=0, all_done=1. start -> PICK and clears all_done.
- warp_valid is sampled at start and held internally. Later changes are ignored until the next start.
- warp_done for a non-active warp is accepted at any time and removes that warp from eligibility.
- Reset mid-operation: all outputs return to reset values next cycle. Any pending swap is discarded.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state encodings (CORE_IDLE..CORE_DONE);
  - the warp_sched_state_t enum;
  - the NUM_WARPS default, shared with the context multiplexer.
- One sub-module, rr_next_warp: combinational round-robin picker taking the eligible mask and current index, returning next index and found flag. Reused by PICK and SWAP.

Test Plan:
- Quantum swap: NUM_WARPS=2, QUANTUM=2, both valid, start. Drive UPDATE every 4 cycles -> warp_select 0,1,0,1 after each second UPDATE; swap pulses one cycle; hold=1 during each swap.
- Memory stall: warp 0 RUN, mem_stall=1 at cycle 10 -> swap=1 at cycle 11, warp_select=1 at cycle 11. Warp 1 mem_stall=0 -> remains selected until its quantum expires.
- Stall without alternative: warp_valid=2'b01, mem_stall=1 for 20 cycles -> warp_select stays 0, swap never pulses.
- Done sequencing: warp 1 done while inactive, then warp 0 asserts done -> FINISH next cycle; all_done=1, busy=0, no swap pulse.
- Simultaneous triggers: core_state==UPDATE with counter at QUANTUM-1, mem_stall=1 and warp_done[active]=1 in the same cycle -> done path taken: single swap to warp 1, counter reset.
- Reset mid-swap: assert reset during the SWAP cycle -> next cycle warp_select=0, swap=0, hold=1, busy=0. start then relaunches from warp 0.
